xc20xx_clbse_bank: RTL and testbench

Parametrised bank of WIDTH CLB storage elements sharing one clock. It generalises the single-bit CLB storage element in three ways: per-channel clock enable and synchronous set/clear, a selectable DFF / TOGGLE / SHIFT mode, and a serial readback port. The readback port captures a snapshot of the bank and shifts it out LSB-first under a small FSM. It sits after the LUT outputs in the XC20XX CLB model and is the storage primitive for multi-bit packed CLB clusters.

---
 rtl/xc20xx_clbse_bank.sv | 155 +++++++++++++++
 tb/tb_xc20xx_clbse_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xc20xx_clbse_bank.sv
// -----------------------------------------------------------------------------
// xc20xx_clbse_bank
//
// A bank of WIDTH CLB storage elements that share one clock. Each channel has
// its own clock enable and synchronous set/clear. The whole bank runs in one
// of three update modes:
//   "DFF"    : Q[i] <= D[i] when CE[i] is high
//   "TOGGLE" : Q[i] <= Q[i] ^ D[i] when CE[i] is high
//   "SHIFT"  : Q <= {Q[WIDTH-2:0], SI} when CE[0] is high
// A readback port snapshots Q into a shadow register and shifts it out
// LSB-first, one bit per RB_SHIFT strobe.
//
// Ports
//   K          clock; all state changes on the rising edge
//   R          synchronous reset, active-high; overrides every other input
//   CE[W]      per-channel clock enable (SHIFT mode uses CE[0] only)
//   D[W]       per-channel data from the LUT F/G outputs
//   SET[W]     per-channel synchronous set; ignores CE
//   CLR[W]     per-channel synchronous clear; ignores CE
//   SI         serial input for SHIFT mode
//   Q[W]       registered storage outputs
//   RB_CAP     readback capture request (honoured in IDLE only)
//   RB_SHIFT   readback shift strobe (honoured in SHIFT only)
//   RB_OUT     current readback bit, shadow[0]
//   RB_BUSY    high while the readback FSM is shifting
//   RB_DONE    one-cycle pulse after the last readback bit is consumed
// -----------------------------------------------------------------------------
module xc20xx_clbse_bank #(
  parameter int               WIDTH   = 4,
  parameter string            MODE    = "DFF",
  parameter string            SR_PRIO = "CLR",
  parameter logic [WIDTH-1:0] INIT    = '0
) (
  input  logic             K,
  input  logic             R,
  input  logic [WIDTH-1:0] CE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] SET,
  input  logic [WIDTH-1:0] CLR,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  input  logic             RB_CAP,
  input  logic             RB_SHIFT,
  output logic             RB_OUT,
  output logic             RB_BUSY,
  output logic             RB_DONE
);

  localparam int  CW       = $clog2(WIDTH + 1);
  localparam bit  IS_DFF   = (MODE == "DFF");
  localparam bit  IS_TOG   = (MODE == "TOGGLE");
  localparam bit  IS_SHIFT = (MODE == "SHIFT");
  // An unrecognised MODE string decodes to none of the above: channels only
  // respond to R and SET/CLR and otherwise hold.
  localparam bit  SET_WINS = (SR_PRIO == "SET");

  typedef enum logic {ST_IDLE, ST_SHIFT} rb_state_e;

  rb_state_e        state_q, state_d;
  logic [WIDTH-1:0] shadow_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] q_mode, q_next;
  logic [WIDTH:0]   shift_ext;
  logic             cap_go, shift_go, last_shift;

  // ---------------------------------------------------------------------------
  // Storage next-state: mode update gated by CE, then SET/CLR override per bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    q_mode    = Q;
    q_next    = Q;
    // Widening by one bit lets WIDTH=1 shift without a zero-width slice.
    shift_ext = {Q, SI};

    if (IS_SHIFT) begin
      if (CE[0]) q_mode = shift_ext[WIDTH-1:0];
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CE[i]) begin
          if (IS_DFF)      q_mode[i] = D[i];
          else if (IS_TOG) q_mode[i] = Q[i] ^ D[i];
        end
      end
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (SET[i] && CLR[i]) q_next[i] = SET_WINS;
      else if (SET[i])      q_next[i] = 1'b1;
      else if (CLR[i])      q_next[i] = 1'b0;
      else                  q_next[i] = q_mode[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Readback FSM next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cap_go     = 1'b0;
    shift_go   = 1'b0;
    last_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // RB_SHIFT is meaningless here, including alongside a capture.
        if (RB_CAP) begin
          cap_go  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (RB_SHIFT) begin
          shift_go   = 1'b1;
          last_shift = (cnt_q == CW'(1));
          if (last_shift) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge K) begin
    // NOTE: non-blocking assignments throughout, so shadow captures the Q
    // value from before this edge while Q itself updates on the same edge.
    if (R) begin
      Q        <= INIT;
      shadow_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
    end else begin
      Q       <= q_next;
      state_q <= state_d;
      done_q  <= last_shift;
      if (cap_go) begin
        shadow_q <= Q;
        cnt_q    <= CW'(WIDTH);
      end else if (shift_go) begin
        shadow_q <= shadow_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

  assign RB_OUT  = shadow_q[0];
  assign RB_BUSY = (state_q == ST_SHIFT);
  assign RB_DONE = done_q;

endmodule

// File: tb/tb_xc20xx_clbse_bank.sv
// -----------------------------------------------------------------------------
// tb_xc20xx_clbse_bank
//
// Five bank instances share one set of stimulus signals:
//   0: WIDTH=4 DFF,    SR_PRIO=CLR, INIT=1010  (DFF, priority, readback)
//   1: WIDTH=4 DFF,    SR_PRIO=SET, INIT=1010  (SET-wins priority)
//   2: WIDTH=4 TOGGLE, SR_PRIO=CLR, INIT=0000
//   3: WIDTH=4 SHIFT,  SR_PRIO=CLR, INIT=0000
//   4: WIDTH=1 DFF,    SR_PRIO=CLR, INIT=0
// Each stimulus cycle pushes the expected post-edge response of one instance
// into a queue; a monitor on the falling edge pops and compares it.
// -----------------------------------------------------------------------------
module tb_xc20xx_clbse_bank;

  logic       K = 1'b0;
  logic       R, SI, RB_CAP, RB_SHIFT;
  logic [3:0] CE, D, SET, CLR;

  logic [3:0] q0, q1, q2, q3;
  logic       q4;
  logic [4:0] busy, rbo, done;

  always #5 K = ~K;

  xc20xx_clbse_bank #(.WIDTH(4), .MODE("DFF"), .SR_PRIO("CLR"), .INIT(4'b1010)) u_dff (
    .K(K), .R(R), .CE(CE), .D(D), .SET(SET), .CLR(CLR), .SI(SI), .Q(q0),
    .RB_CAP(RB_CAP), .RB_SHIFT(RB_SHIFT), .RB_OUT(rbo[0]), .RB_BUSY(busy[0]), .RB_DONE(done[0]));

  xc20xx_clbse_bank #(.WIDTH(4), .MODE("DFF"), .SR_PRIO("SET"), .INIT(4'b1010)) u_set (
    .K(K), .R(R), .CE(CE), .D(D), .SET(SET), .CLR(CLR), .SI(SI), .Q(q1),
    .RB_CAP(RB_CAP), .RB_SHIFT(RB_SHIFT), .RB_OUT(rbo[1]), .RB_BUSY(busy[1]), .RB_DONE(done[1]));

  xc20xx_clbse_bank #(.WIDTH(4), .MODE("TOGGLE"), .SR_PRIO("CLR"), .INIT(4'b0000)) u_tog (
    .K(K), .R(R), .CE(CE), .D(D), .SET(SET), .CLR(CLR), .SI(SI), .Q(q2),
    .RB_CAP(RB_CAP), .RB_SHIFT(RB_SHIFT), .RB_OUT(rbo[2]), .RB_BUSY(busy[2]), .RB_DONE(done[2]));

  xc20xx_clbse_bank #(.WIDTH(4), .MODE("SHIFT"), .SR_PRIO("CLR"), .INIT(4'b0000)) u_shf (
    .K(K), .R(R), .CE(CE), .D(D), .SET(SET), .CLR(CLR), .SI(SI), .Q(q3),
    .RB_CAP(RB_CAP), .RB_SHIFT(RB_SHIFT), .RB_OUT(rbo[3]), .RB_BUSY(busy[3]), .RB_DONE(done[3]));

  xc20xx_clbse_bank #(.WIDTH(1), .MODE("DFF"), .SR_PRIO("CLR"), .INIT(1'b0)) u_w1 (
    .K(K), .R(R), .CE(CE[0]), .D(D[0]), .SET(SET[0]), .CLR(CLR[0]), .SI(SI), .Q(q4),
    .RB_CAP(RB_CAP), .RB_SHIFT(RB_SHIFT), .RB_OUT(rbo[4]), .RB_BUSY(busy[4]), .RB_DONE(done[4]));

  typedef struct {
    int         id;
    bit         cq;
    logic [3:0] q;
    bit         cr;
    logic       b;
    logic       o;
    logic       d;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // Monitor: compares the post-edge outputs of the selected instance.
  always @(negedge K) begin
    exp_t       e;
    logic [3:0] aq;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       aq = q0;
        1:       aq = q1;
        2:       aq = q2;
        3:       aq = q3;
        default: aq = {3'b000, q4};
      endcase
      if (e.cq) check({e.nm, ".q"}, aq, e.q);
      if (e.cr) begin
        check({e.nm, ".busy"}, {3'b000, busy[e.id]}, {3'b000, e.b});
        check({e.nm, ".out"},  {3'b000, rbo[e.id]},  {3'b000, e.o});
        check({e.nm, ".done"}, {3'b000, done[e.id]}, {3'b000, e.d});
      end
    end
  end

  // Push the expected response for the coming edge, then advance one cycle.
  task automatic step(input int id, input bit cq, input logic [3:0] q,
                      input bit cr, input logic b, input logic o, input logic d,
                      input string nm);
    exp_t e;
    e.id = id; e.cq = cq; e.q = q; e.cr = cr; e.b = b; e.o = o; e.d = d; e.nm = nm;
    sb.push_back(e);
    @(posedge K);
    #1;
  endtask

  initial begin
    R = 1'b1; CE = '0; D = '0; SET = '0; CLR = '0; SI = 1'b0;
    RB_CAP = 1'b0; RB_SHIFT = 1'b0;

    // Reset and DFF mode
    step(0, 1, 4'b1010, 1, 0, 0, 0, "reset");
    R = 1'b0; D = 4'b0101; CE = 4'b1111;
    step(0, 1, 4'b0101, 1, 0, 0, 0, "dff_all");
    D = 4'b1111; CE = 4'b0011;
    step(0, 1, 4'b0111, 0, 0, 0, 0, "dff_partial_ce");

    // Set/clear priority
    SET = 4'b0001; CLR = 4'b0001; D = 4'b1111; CE = 4'b1111;
    step(0, 1, 4'b1110, 0, 0, 0, 0, "prio_clr");
    D = 4'b0000;
    step(1, 1, 4'b0001, 0, 0, 0, 0, "prio_set");
    SET = 4'b1000; CLR = 4'b0000; CE = 4'b0000;
    step(1, 1, 4'b1001, 0, 0, 0, 0, "set_ignores_ce");
    R = 1'b1; SET = 4'b1111;
    step(0, 1, 4'b1010, 0, 0, 0, 0, "reset_over_set");
    R = 1'b0; SET = 4'b0000;

    // TOGGLE mode
    D = 4'b1001; CE = 4'b1111;
    step(2, 1, 4'b1001, 0, 0, 0, 0, "tog1");
    step(2, 1, 4'b0000, 0, 0, 0, 0, "tog2");
    step(2, 1, 4'b1001, 0, 0, 0, 0, "tog3");
    CE = 4'b0000;
    step(2, 1, 4'b1001, 0, 0, 0, 0, "tog_hold");

    // SHIFT mode
    D = 4'b0000; CE = 4'b0001;
    SI = 1'b1; step(3, 1, 4'b0001, 0, 0, 0, 0, "shf1");
    SI = 1'b0; step(3, 1, 4'b0010, 0, 0, 0, 0, "shf2");
    SI = 1'b1; step(3, 1, 4'b0101, 0, 0, 0, 0, "shf3");
    SI = 1'b1; step(3, 1, 4'b1011, 0, 0, 0, 0, "shf4");
    R = 1'b1;  step(3, 1, 4'b0000, 0, 0, 0, 0, "shf_reset");
    R = 1'b0;
    SI = 1'b1; step(3, 1, 4'b0001, 0, 0, 0, 0, "shfb1");
    SI = 1'b0; step(3, 1, 4'b0010, 0, 0, 0, 0, "shfb2");
    SI = 1'b1; step(3, 1, 4'b0101, 0, 0, 0, 0, "shfb3");
    SI = 1'b1; CLR = 4'b0010;
    step(3, 1, 4'b1001, 0, 0, 0, 0, "shfb4_clr");
    CLR = 4'b0000; SI = 1'b0;

    // Readback of Q=1101 while Q keeps loading D
    D = 4'b1101; CE = 4'b1111;
    step(0, 1, 4'b1101, 1, 0, 0, 0, "rb_setup");
    RB_CAP = 1'b1; D = 4'b0000;
    step(0, 1, 4'b0000, 1, 1, 1, 0, "rb_cap");
    RB_CAP = 1'b0; RB_SHIFT = 1'b1; D = 4'b1111;
    step(0, 1, 4'b1111, 1, 1, 0, 0, "rb_s1");
    RB_CAP = 1'b1; D = 4'b0011;
    step(0, 1, 4'b0011, 1, 1, 1, 0, "rb_s2_cap_ignored");
    RB_CAP = 1'b0; D = 4'b0101;
    step(0, 1, 4'b0101, 1, 1, 1, 0, "rb_s3");
    D = 4'b0110;
    step(0, 1, 4'b0110, 1, 0, 0, 1, "rb_done");

    // Capture right after DONE, then abort by reset after two shifts
    RB_SHIFT = 1'b0; RB_CAP = 1'b1; D = 4'b1001;
    step(0, 1, 4'b1001, 1, 1, 0, 0, "rb_recap");
    RB_CAP = 1'b0; RB_SHIFT = 1'b1;
    step(0, 0, 4'b0000, 1, 1, 1, 0, "ab_s1");
    step(0, 0, 4'b0000, 1, 1, 1, 0, "ab_s2");
    R = 1'b1;
    step(0, 1, 4'b1010, 1, 0, 0, 0, "ab_reset");
    R = 1'b0; CE = 4'b0000;
    step(0, 1, 4'b1010, 1, 0, 0, 0, "ab_no_done");

    // CAP and SHIFT together in IDLE: capture only, full four shifts follow
    RB_CAP = 1'b1;
    step(0, 0, 4'b0000, 1, 1, 0, 0, "cs_cap");
    RB_CAP = 1'b0;
    step(0, 0, 4'b0000, 1, 1, 1, 0, "cs_s1");
    step(0, 0, 4'b0000, 1, 1, 0, 0, "cs_s2");
    step(0, 0, 4'b0000, 1, 1, 1, 0, "cs_s3");
    step(0, 0, 4'b0000, 1, 0, 0, 1, "cs_done");

    // WIDTH=1: done after a single shift
    RB_SHIFT = 1'b0; CE = 4'b1111; D = 4'b0001;
    step(4, 1, 4'b0001, 1, 0, 0, 0, "w1_load");
    CE = 4'b0000; RB_CAP = 1'b1;
    step(4, 1, 4'b0001, 1, 1, 1, 0, "w1_cap");
    RB_CAP = 1'b0; RB_SHIFT = 1'b1;
    step(4, 1, 4'b0001, 1, 0, 0, 1, "w1_done");
    RB_SHIFT = 1'b0;
    step(4, 0, 4'b0000, 1, 0, 0, 0, "w1_pulse_end");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge K);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
